// File: rtl/dpram_be_clr_pkg.sv
// dpram_be_clr_pkg
// Shared types and helpers for the byte-enable dual-port RAM with zero-clear
// sweep.
//   state_t      : sweep / ready controller states
//   BE_WIDTH     : byte-enable width for the default 32-bit word
//   merge_bytes  : replaces the enabled byte lanes of a word. The write path and
//                  the collision bypass both use it, so the two results are the same.
//                  It works on MAX_DATA_WIDTH bits, so callers size-cast the
//                  arguments and the result to their own word width.
package dpram_be_clr_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;
   localparam int MAX_DATA_WIDTH = 1024;
   localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

   function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_BE_WIDTH-1:0]   be
   );
      logic [MAX_DATA_WIDTH-1:0] res;
      res = old_word;
      for (int k = 0; k < MAX_BE_WIDTH; k++) begin
         if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dpram_be_clr_if.sv
// dpram_be_clr_if
// Write port A, read port B and the sweep control/status of dpram_be_clr.
//   i_we_a / i_be_a / i_addr_a / i_data_a : byte-enabled write
//   i_en_b / i_addr_b                     : read request
//   o_data_b / o_valid_b                  : read result and its one-cycle strobe
//   i_clear / o_init_done                 : sweep request, ready status
// The slave modport is the RAM side. The master modport is the user side.
interface dpram_be_clr_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   localparam int BE_W = DATA_WIDTH / 8;

   logic                  i_we_a;
   logic [BE_W-1:0]       i_be_a;
   logic [ADDR_WIDTH-1:0] i_addr_a;
   logic [DATA_WIDTH-1:0] i_data_a;
   logic                  i_en_b;
   logic [ADDR_WIDTH-1:0] i_addr_b;
   logic [DATA_WIDTH-1:0] o_data_b;
   logic                  o_valid_b;
   logic                  i_clear;
   logic                  o_init_done;

   modport slave (
      input  i_we_a, i_be_a, i_addr_a, i_data_a, i_en_b, i_addr_b, i_clear,
      output o_data_b, o_valid_b, o_init_done
   );

   modport master (
      output i_we_a, i_be_a, i_addr_a, i_data_a, i_en_b, i_addr_b, i_clear,
      input  o_data_b, o_valid_b, o_init_done
   );
endinterface

// File: rtl/dpram_rd_pipe.sv
// dpram_rd_pipe
// Delay line of {valid, data}, DEPTH stages (DEPTH >= 1).
// Only the valids are cleared, by a synchronous active-low reset. The data
// stages have no reset.
//   i_clk, i_rst_n    : clock, synchronous active-low clear of the valids
//   d_valid, d_data   : stage input
//   q_valid, q_data   : output after DEPTH cycles
module dpram_rd_pipe #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_data,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_data
);
   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         vld <= '0;
      end else begin
         vld[0] <= d_valid;
         for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
      end
   end

   always_ff @(posedge i_clk) begin
      dat[0] <= d_data;
      for (int i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
   end

   assign q_valid = vld[DEPTH-1];
   assign q_data  = dat[DEPTH-1];
endmodule

// File: rtl/dpram_be_clr.sv
// dpram_be_clr
// Single-clock RAM with one write port and one read port. It has per-byte
// write enables and a read-valid strobe after OUT_DELAY cycles. A read that hits
// a same-cycle write to the same address can optionally see the new data
// (BYPASS). A hardware sweep writes zero to every word.
//   i_clk, i_rst_n : clock, synchronous active-low reset (RAM contents untouched)
//   bus (slave)    : write port A, read port B, i_clear / o_init_done
//
// state    | meaning
// ST_CLEAR | sweep writes zero at clr_cnt, one word per cycle; user writes dropped
// ST_READY | user writes accepted; i_clear starts a new sweep
module dpram_be_clr
   import dpram_be_clr_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int RAM_DEPTH      = 1024,
   parameter int OUT_DELAY      = 1,
   parameter int BYPASS         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   dpram_be_clr_if.slave bus
);
   localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   state_t                state;
   logic [IDX_W-1:0]      clr_cnt;
   logic                  init_done_q;

   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic                  wr_in_range;
   logic                  rd_in_range;
   logic                  wr_ok;
   logic                  sweep_we;
   logic                  collide;
   logic [DATA_WIDTH-1:0] wr_merged;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] byp_word;

   logic                  s1_valid;
   logic [DATA_WIDTH-1:0] s1_data;
   logic                  p_valid;
   logic [DATA_WIDTH-1:0] p_data;
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   assign wr_idx      = bus.i_addr_a[IDX_W-1:0];
   assign rd_idx      = bus.i_addr_b[IDX_W-1:0];
   assign wr_in_range = 32'(bus.i_addr_a) < RAM_DEPTH;
   assign rd_in_range = 32'(bus.i_addr_b) < RAM_DEPTH;

   // Both the sweep and user writes wait for reset release, so reset itself
   // never changes a word.
   assign sweep_we = i_rst_n && (state == ST_CLEAR);
   assign wr_ok    = i_rst_n && (state == ST_READY) && bus.i_we_a && wr_in_range;

   assign wr_merged = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(mem[wr_idx]),
                                              MAX_DATA_WIDTH'(bus.i_data_a),
                                              MAX_BE_WIDTH'(bus.i_be_a)));

   assign rd_word  = rd_in_range ? mem[rd_idx] : '0;
   assign byp_word = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(rd_word),
                                             MAX_DATA_WIDTH'(bus.i_data_a),
                                             MAX_BE_WIDTH'(bus.i_be_a)));
   // Only a write that actually lands can be forwarded to the reader.
   assign collide  = (BYPASS != 0) && wr_ok && (bus.i_addr_a == bus.i_addr_b);

   always_ff @(posedge i_clk) begin
      if (sweep_we) mem[clr_cnt] <= '0;
      else if (wr_ok) mem[wr_idx] <= wr_merged;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_cnt     <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (32'(clr_cnt) == RAM_DEPTH - 1) begin
                  state       <= ST_READY;
                  init_done_q <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + IDX_W'(1);
               end
            end
            ST_READY: begin
               if (bus.i_clear) begin
                  state       <= ST_CLEAR;
                  clr_cnt     <= '0;
                  init_done_q <= 1'b0;
               end else begin
                  init_done_q <= 1'b1;
               end
            end
            default: state <= ST_READY;
         endcase
      end
   end

   // First read stage: the array is sampled in the request cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) s1_valid <= 1'b0;
      else          s1_valid <= bus.i_en_b;
   end

   always_ff @(posedge i_clk) begin
      if (bus.i_en_b) s1_data <= collide ? byp_word : rd_word;
   end

   if (OUT_DELAY > 1) begin : g_pipe
      dpram_rd_pipe #(
         .DEPTH (OUT_DELAY - 1),
         .WIDTH (DATA_WIDTH)
      ) u_rd_pipe (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .d_valid (s1_valid),
         .d_data  (s1_data),
         .q_valid (p_valid),
         .q_data  (p_data)
      );
   end else begin : g_nopipe
      assign p_valid = s1_valid;
      assign p_data  = s1_data;
   end

   // The output register holds the last valid result between reads.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= p_valid;
         if (p_valid) out_data_q <= p_data;
      end
   end

   assign bus.o_valid_b   = out_valid_q;
   assign bus.o_data_b    = out_data_q;
   assign bus.o_init_done = init_done_q;
endmodule

// File: tb/tb_dpram_be_clr.sv
module tb_dpram_be_clr;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 16;
   localparam int OD_A  = 3;
   localparam int OD_B  = 1;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dpram_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
   dpram_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

   dpram_be_clr #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
      .OUT_DELAY(OD_A), .BYPASS(1), .CLEAR_ON_RESET(1)
   ) dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_a)
   );

   dpram_be_clr #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
      .OUT_DELAY(OD_B), .BYPASS(0), .CLEAR_ON_RESET(1)
   ) dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_b)
   );

   logic [1:0]  o_valid;
   logic [1:0]  o_done;
   logic [31:0] o_data [2];
   assign o_valid[0] = bus_a.o_valid_b;
   assign o_valid[1] = bus_b.o_valid_b;
   assign o_done[0]  = bus_a.o_init_done;
   assign o_done[1]  = bus_b.o_init_done;
   assign o_data[0]  = bus_a.o_data_b;
   assign o_data[1]  = bus_b.o_data_b;

   exp_t        q [2][$];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] last_data [2];
   int          cyc = 0;
   int          sweep_last = 0;
   bit          in_reset = 1'b1;
   int          checks = 0;
   int          failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] tb_merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (o & ~m) | (n & m);
   endfunction

   function automatic int od_of(int i);
      return (i == 0) ? OD_A : OD_B;
   endfunction

   // Output monitor: valid pulses, read data, held data and ready status.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         exp_t        e;
         logic        hit;
         logic        exp_done;
         hit      = (q[i].size() > 0) && (q[i][0].due == cyc);
         exp_done = !in_reset && (cyc >= sweep_last);
         checks++;
         assert (o_valid[i] === hit) else begin
            failures++;
            $error("FAIL valid_dut%0d cyc=%0d observed=%b expected=%b", i, cyc, o_valid[i], hit);
         end
         if (hit) begin
            e = q[i].pop_front();
            if (o_valid[i] === 1'b1) begin
               checks++;
               assert (o_data[i] === e.data) else begin
                  failures++;
                  $error("FAIL rdata_dut%0d cyc=%0d observed=%h expected=%h", i, cyc, o_data[i], e.data);
               end
               last_data[i] = e.data;
            end
         end else begin
            checks++;
            assert (o_data[i] === last_data[i]) else begin
               failures++;
               $error("FAIL hold_dut%0d cyc=%0d observed=%h expected=%h", i, cyc, o_data[i], last_data[i]);
            end
         end
         checks++;
         assert (o_done[i] === exp_done) else begin
            failures++;
            $error("FAIL init_done_dut%0d cyc=%0d observed=%b expected=%b", i, cyc, o_done[i], exp_done);
         end
      end
   end

   task automatic drive(input bit we, input logic [3:0] be, input int aa, input logic [31:0] da,
                        input bit en, input int ab, input bit clr);
      bus_a.i_we_a = we;  bus_a.i_be_a = be;  bus_a.i_addr_a = AW'(aa); bus_a.i_data_a = da;
      bus_a.i_en_b = en;  bus_a.i_addr_b = AW'(ab); bus_a.i_clear = clr;
      bus_b.i_we_a = we;  bus_b.i_be_a = be;  bus_b.i_addr_a = AW'(aa); bus_b.i_data_a = da;
      bus_b.i_en_b = en;  bus_b.i_addr_b = AW'(ab); bus_b.i_clear = clr;
   endtask

   // One request cycle. The model works out what this request must produce
   // at the next clock edge.
   task automatic step(input bit we, input logic [3:0] be, input int aa, input logic [31:0] da,
                       input bit en, input int ab, input bit clr);
      int          up;
      bit          ready;
      bit          wr_hit;
      logic [31:0] old;
      exp_t        e;
      @(negedge clk);
      #1;
      drive(we, be, aa, da, en, ab, clr);
      up     = cyc + 1;
      ready  = up > sweep_last;
      wr_hit = we && ready && (aa < DEPTH);
      if (en) begin
         old = (ab < DEPTH) ? ref_mem[ab] : 32'h0;
         for (int i = 0; i < 2; i++) begin
            e.due  = up + od_of(i);
            e.data = (i == 0 && wr_hit && aa == ab) ? tb_merge(old, da, be) : old;
            q[i].push_back(e);
         end
      end
      if (wr_hit) ref_mem[aa] = tb_merge(ref_mem[aa], da, be);
      if (clr && ready) begin
         sweep_last = up + DEPTH;
         for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'h0;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 4'h0, 0, 32'h0, 0, 0, 0);
   endtask

   task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
      step(1, be, a, d, 0, 0, 0);
   endtask

   task automatic rd(input int a);
      step(0, 4'h0, 0, 32'h0, 1, a, 0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1;
      sweep_last = cyc + DEPTH;
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'h0;
      in_reset = 1'b0;
      rst_n    = 1'b1;
   endtask

   task automatic reset_pulse(input int n);
      @(negedge clk);
      #1;
      rst_n    = 1'b0;
      in_reset = 1'b1;
      drive(0, 4'h0, 0, 32'h0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         q[i].delete();
         last_data[i] = 32'h0;
      end
      repeat (n) @(posedge clk);
      release_reset();
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 4'h0, 0, 32'h0, 0, 0, 0);
      last_data[0] = 32'h0;
      last_data[1] = 32'h0;
      repeat (2) @(posedge clk);
      release_reset();

      // Sweep after reset, then a read of a cleared word.
      idle(17);
      rd(5);
      idle(4);

      // Byte merge.
      wr(3, 32'hAABBCCDD, 4'hF);
      wr(3, 32'h11223344, 4'b0101);
      rd(3);
      idle(4);

      // Same-cycle collision on address 7, then a follow-up read.
      step(1, 4'hF, 7, 32'hDEADBEEF, 1, 7, 0);
      rd(7);
      idle(4);

      // Back-to-back reads, in order.
      wr(0, 32'h0000_0100, 4'hF);
      wr(1, 32'h0000_0101, 4'hF);
      wr(2, 32'h0000_0102, 4'hF);
      rd(0);
      rd(1);
      rd(2);
      idle(4);

      // Clear request: a write during the sweep is dropped. Then an out-of-range read.
      wr(2, 32'h5, 4'hF);
      step(0, 4'h0, 0, 32'h0, 0, 0, 1);
      wr(4, 32'h77, 4'hF);
      idle(17);
      rd(2);
      rd(4);
      rd(20);
      idle(4);

      // Random traffic: partial writes, out-of-range addresses, collisions.
      for (int n = 0; n < 250; n++) begin
         int aa;
         int ab;
         aa = int'($urandom_range(0, 19));
         ab = ($urandom_range(0, 3) == 0) ? aa : int'($urandom_range(0, 19));
         step(1'($urandom_range(0, 1)), 4'($urandom), aa, $urandom,
              1'($urandom_range(0, 1)), ab, 0);
      end
      idle(4);

      // Reset during a sweep with reads in flight.
      step(0, 4'h0, 0, 32'h0, 0, 0, 1);
      idle(7);
      rd(0);
      rd(1);
      reset_pulse(1);
      idle(17);
      for (int k = 0; k < DEPTH; k++) rd(k);
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
